serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_if.sv | 39 +++
 rtl/serial_subtractor.sv | 107 ++++++++++
 tb/tb_serial_subtractor.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Operand and result handshakes for the bit-serial subtractor.
// The master side drives operands and accepts results.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output in_valid,
        output a,
        output b,
        output bin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  diff,
        input  bout
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  bin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output diff,
        output bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, one bit per clock LSB first.
// Difference assembles from the MSB side; borrow carried in a flop.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    serial_subtractor_if.slave io
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic a0;
    logic b0;
    logic d_bit;
    logic br_next;
    logic last_bit;

    always_comb begin
        a0       = a_q[0];
        b0       = b_q[0];
        d_bit    = a0 ^ b0 ^ br_q;
        br_next  = (~a0 & b0) | (~(a0 ^ b0) & br_q);
        last_bit = (cnt_q == CW'(WIDTH - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    a_d     = io.a;
                    b_d     = io.b;
                    br_d    = io.bin;
                    cnt_d   = '0;
                    diff_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                diff_d = {d_bit, diff_q[WIDTH-1:1]};
                a_d    = {1'b0, a_q[WIDTH-1:1]};
                b_d    = {1'b0, b_q[WIDTH-1:1]};
                br_d   = br_next;
                cnt_d  = cnt_q + CW'(1);
                // Final bit: its borrow is the operation's borrow-out.
                if (last_bit) begin
                    bout_d  = br_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake flags come straight from the state register.
    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);
    assign io.diff      = diff_q;
    assign io.bout      = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH 8 and 16.
// Expected results queue up at accept and are popped on out_valid.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8))  io8 ();
    serial_subtractor_if #(.WIDTH(16)) io16 ();

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .io  (io8)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .io  (io16)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [8:0]  q8[$];
    logic [16:0] q16[$];

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] model8(logic [7:0] a, logic [7:0] b,
                                          logic bi);
        return {1'b0, a} - {1'b0, b} - 9'(bi);
    endfunction

    function automatic logic [16:0] model16(logic [15:0] a, logic [15:0] b,
                                            logic bi);
        return {1'b0, a} - {1'b0, b} - 17'(bi);
    endfunction

    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic bi, input bit scramble, input string tag);
        int         lat;
        bit         seen;
        bit         ir_bad;
        logic [8:0] e;
        chk({tag, " ready"}, 64'(io8.in_ready), 64'd1);
        io8.a        = a;
        io8.b        = b;
        io8.bin      = bi;
        io8.in_valid = 1'b1;
        q8.push_back(model8(a, b, bi));
        step();
        io8.in_valid = 1'b0;
        lat    = 0;
        seen   = 1'b0;
        ir_bad = 1'b0;
        while (!seen && lat < 40) begin
            if (io8.in_ready) ir_bad = 1'b1;
            if (scramble) begin
                io8.a   = 8'($urandom);
                io8.b   = 8'($urandom);
                io8.bin = 1'($urandom);
            end
            step();
            lat++;
            if (io8.out_valid) seen = 1'b1;
        end
        chk({tag, " latency"}, 64'(lat), 64'd8);
        chk({tag, " in_ready low"}, 64'(ir_bad | io8.in_ready), 64'd0);
        e = q8.pop_front();
        chk({tag, " result"}, 64'({io8.bout, io8.diff}), 64'(e));
        io8.out_ready = 1'b1;
        step();
        io8.out_ready = 1'b0;
        chk({tag, " idle"}, 64'({io8.in_ready, io8.out_valid}), 64'b10);
    endtask

    task automatic rand8(input int n);
        int         accepts;
        int         last;
        int         guard;
        logic [8:0] e;
        accepts = 0;
        last    = -1;
        guard   = 0;
        io8.in_valid  = 1'b1;
        io8.out_ready = 1'b1;
        while ((accepts < n || q8.size() > 0) && guard < n * 20 + 100) begin
            if (io8.out_valid) begin
                e = q8.pop_front();
                chk("r8 result", 64'({io8.bout, io8.diff}), 64'(e));
            end
            if (io8.in_ready && accepts < n) begin
                if (last >= 0) chk("r8 interval", 64'(cyc - last), 64'd10);
                last    = cyc;
                io8.a   = 8'($urandom);
                io8.b   = 8'($urandom);
                io8.bin = 1'($urandom);
                q8.push_back(model8(io8.a, io8.b, io8.bin));
                accepts++;
            end else begin
                io8.a   = 8'($urandom);
                io8.b   = 8'($urandom);
                io8.bin = 1'($urandom);
                if (accepts >= n) io8.in_valid = 1'b0;
            end
            step();
            guard++;
        end
        chk("r8 drained", 64'(q8.size()), 64'd0);
        chk("r8 count", 64'(accepts), 64'(n));
        io8.in_valid  = 1'b0;
        io8.out_ready = 1'b0;
    endtask

    task automatic rand16(input int n);
        int          accepts;
        int          last;
        int          guard;
        logic [16:0] e;
        accepts = 0;
        last    = -1;
        guard   = 0;
        io16.in_valid  = 1'b1;
        io16.out_ready = 1'b1;
        while ((accepts < n || q16.size() > 0) && guard < n * 30 + 100) begin
            if (io16.out_valid) begin
                e = q16.pop_front();
                chk("r16 result", 64'({io16.bout, io16.diff}), 64'(e));
            end
            if (io16.in_ready && accepts < n) begin
                if (last >= 0) chk("r16 interval", 64'(cyc - last), 64'd18);
                last     = cyc;
                io16.a   = 16'($urandom);
                io16.b   = 16'($urandom);
                io16.bin = 1'($urandom);
                q16.push_back(model16(io16.a, io16.b, io16.bin));
                accepts++;
            end else begin
                io16.a   = 16'($urandom);
                io16.b   = 16'($urandom);
                io16.bin = 1'($urandom);
                if (accepts >= n) io16.in_valid = 1'b0;
            end
            step();
            guard++;
        end
        chk("r16 drained", 64'(q16.size()), 64'd0);
        chk("r16 count", 64'(accepts), 64'(n));
        io16.in_valid  = 1'b0;
        io16.out_ready = 1'b0;
    endtask

    initial begin
        int         lat;
        logic [8:0] e;
        rst            = 1'b1;
        io8.in_valid   = 1'b0;
        io8.out_ready  = 1'b0;
        io8.a          = '0;
        io8.b          = '0;
        io8.bin        = 1'b0;
        io16.in_valid  = 1'b0;
        io16.out_ready = 1'b0;
        io16.a         = '0;
        io16.b         = '0;
        io16.bin       = 1'b0;
        step();
        step();
        chk("reset8", 64'({io8.in_ready, io8.out_valid, io8.bout, io8.diff}),
            64'({1'b1, 1'b0, 1'b0, 8'h00}));
        chk("reset16",
            64'({io16.in_ready, io16.out_valid, io16.bout, io16.diff}),
            64'({1'b1, 1'b0, 1'b0, 16'h0000}));
        rst = 1'b0;
        step();

        op8(8'h5A, 8'h3C, 1'b0, 1'b0, "t1");
        chk("t1 value", 64'({io8.bout, io8.diff}), 64'h01E);
        op8(8'h00, 8'h01, 1'b0, 1'b0, "t2");
        chk("t2 value", 64'({io8.bout, io8.diff}), 64'h1FF);
        op8(8'h10, 8'h10, 1'b1, 1'b0, "t3");
        chk("t3 value", 64'({io8.bout, io8.diff}), 64'h1FF);
        op8(8'h80, 8'h7F, 1'b1, 1'b0, "t4");
        chk("t4 value", 64'({io8.bout, io8.diff}), 64'h000);
        op8(8'h3C, 8'h3C, 1'b0, 1'b0, "eq0");
        chk("eq0 value", 64'({io8.bout, io8.diff}), 64'h000);
        op8(8'h00, 8'hFF, 1'b1, 1'b0, "zmax");
        chk("zmax value", 64'({io8.bout, io8.diff}), 64'h100);

        // Backpressure with ignored in_valid pulses during the stall.
        io8.a        = 8'hC3;
        io8.b        = 8'h4D;
        io8.bin      = 1'b1;
        io8.in_valid = 1'b1;
        q8.push_back(model8(8'hC3, 8'h4D, 1'b1));
        step();
        io8.in_valid = 1'b0;
        lat = 0;
        while (!io8.out_valid && lat < 40) begin
            step();
            lat++;
        end
        chk("bp latency", 64'(lat), 64'd8);
        e = q8[0];
        for (int k = 0; k < 5; k++) begin
            chk("bp hold", 64'({io8.out_valid, io8.in_ready, io8.bout, io8.diff}),
                64'({2'b10, e}));
            io8.in_valid = (k == 1 || k == 3);
            io8.a        = 8'hFF;
            io8.b        = 8'h00;
            io8.bin      = 1'b0;
            step();
        end
        io8.in_valid = 1'b0;
        chk("bp final", 64'({io8.out_valid, io8.bout, io8.diff}), 64'({1'b1, e}));
        void'(q8.pop_front());
        io8.out_ready = 1'b1;
        step();
        io8.out_ready = 1'b0;
        chk("bp idle", 64'({io8.in_ready, io8.out_valid}), 64'b10);
        chk("bp kept", 64'({io8.bout, io8.diff}), 64'(e));
        step();
        step();
        chk("bp no stale", 64'({io8.in_ready, io8.out_valid}), 64'b10);

        // Abort during the third RUN cycle.
        io8.a        = 8'hAA;
        io8.b        = 8'h11;
        io8.bin      = 1'b0;
        io8.in_valid = 1'b1;
        step();
        io8.in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        chk("abort", 64'({io8.in_ready, io8.out_valid, io8.bout, io8.diff}),
            64'({1'b1, 1'b0, 1'b0, 8'h00}));
        rst = 1'b0;
        step();
        op8(8'h03, 8'h05, 1'b0, 1'b0, "post");
        chk("post value", 64'({io8.bout, io8.diff}), 64'h1FE);

        op8(8'hA5, 8'h5A, 1'b1, 1'b1, "scr");
        chk("scr value", 64'({io8.bout, io8.diff}), 64'h04A);

        rand8(1000);
        rand16(1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
